wallace_mult_pipe: RTL and testbench

- Parametrised, pipelined Wallace-tree multiplier; successor to the fixed 4x4 combinational multiplier.
- Width is generic, with selectable signed/unsigned mode per operation and a configurable number of pipeline register stages.
- Uses a valid/ready handshake on input and output, so it can sit between streaming producers and consumers in the datapath with backpressure.

---
 rtl/wallace_mult_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_wallace_mult_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mult_pipe.sv
// ---------------------------------------------------------------------------
// wallace_mult_pipe
//   Pipelined, parametrised Wallace-tree multiplier with valid/ready
//   handshakes on both sides. Each operation selects signed (Baugh-Wooley)
//   or unsigned (plain AND array) partial products. The rows are reduced
//   by 3:2 carry-save layers down to two rows. The final carry-propagate
//   adder feeds the registered product.
//
//   Parameters
//     N       operand width (4..32)
//     STAGES  register stages from input capture to prod (1..4)
//
//   Ports
//     clk, rst             clock, asynchronous active-high reset
//     in_valid / in_ready  input handshake (in_ready is combinational)
//     mp, ml, sgn          operands and signed-mode select
//     out_valid/out_ready  output handshake
//     prod                 registered 2N-bit exact product
//
//   Optional feature (macro WALLACE_MULT_ACC_EN)
//     acc_clr  input, travels with the transaction
//     acc      2N+4-bit running sum of extended products. It is updated
//              on each output transfer.
// ---------------------------------------------------------------------------
module wallace_mult_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   mp,
  input  logic [N-1:0]   ml,
  input  logic           sgn,
`ifdef WALLACE_MULT_ACC_EN
  input  logic           acc_clr,
  output logic [2*N+3:0] acc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod
);

  localparam int W  = 2 * N;
  localparam int R  = N + 1;                    // N partial products + correction row
  localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

  typedef logic [R-1:0][W-1:0] rows_t;

  localparam logic [W-1:0] ONE_W   = {{(W-1){1'b0}}, 1'b1};
  // Baugh-Wooley constant: ones at bit N and bit 2N-1
  localparam logic [W-1:0] BW_CORR = (ONE_W << N) | (ONE_W << (W - 1));

  // Row count after one 3:2 layer: each full triple becomes two rows.
  function automatic int next_cnt(input int c);
    return (c / 3) * 2 + (c % 3);
  endfunction

  function automatic int count_layers();
    int c;
    int l;
    c = R;
    l = 0;
    for (int k = 0; k < 64; k++) begin
      if (c > 2) begin
        c = next_cnt(c);
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int L = count_layers();

  // Partial products. In signed mode the cross terms holding exactly one
  // sign bit are inverted. The correction constant is also added.
  function automatic rows_t pp_gen(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic s);
    rows_t       r;
    logic [W-1:0] row;
    r = '0;
    for (int j = 0; j < N; j++) begin
      row = '0;
      for (int i = 0; i < N; i++) begin
        row[i+j] = (a[i] & b[j]) ^ (s & ((i == N - 1) != (j == N - 1)));
      end
      r[j] = row;
    end
    r[N] = s ? BW_CORR : '0;
    return r;
  endfunction

  // One carry-save layer applies full adders to every complete triple of
  // rows. The 0-2 leftover rows pass through unchanged.
  function automatic rows_t csa_layer(input rows_t x, input int cnt);
    rows_t y;
    int    g;
    y = '0;
    g = cnt / 3;
    for (int i = 0; i < R / 3; i++) begin
      if (i < g) begin
        y[2*i]   = x[3*i] ^ x[3*i+1] ^ x[3*i+2];
        y[2*i+1] = ((x[3*i] & x[3*i+1]) | (x[3*i] & x[3*i+2]) |
                    (x[3*i+1] & x[3*i+2])) << 1;
      end
    end
    for (int r = 0; r < R; r++) begin
      if ((r >= 3 * g) && (r < cnt)) begin
        y[r-g] = x[r];
      end
    end
    return y;
  endfunction

  // Apply the layers in the index range [lo, hi) of the reduction tree.
  function automatic rows_t reduce_span(input rows_t x, input int lo, input int hi);
    rows_t y;
    int    c;
    y = x;
    c = R;
    for (int k = 0; k < L; k++) begin
      if ((k >= lo) && (k < hi)) begin
        y = csa_layer(y, c);
      end
      c = next_cnt(c);
    end
    return y;
  endfunction

  function automatic logic [W-1:0] cpa(input rows_t x);
    return x[0] + x[1];
  endfunction

  logic                    adv_s;
  rows_t                   stg_in_s  [STAGES];
  rows_t                   stg_out_s [STAGES];
  logic [STAGES-1:0]       stg_vld_s;
  rows_t                   rows_r    [NR];
  logic [NR-1:0]           vld_r;
  logic [W-1:0]            sum_s;

  // The whole pipeline advances when the output slot is empty or draining.
  always_comb begin
    adv_s = ~out_valid | out_ready;
  end

  assign in_ready = adv_s;

  // Compressor layers are split as evenly as integer division allows.
  // Stage 0 takes the live inputs; later stages take their register.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign stg_in_s[s]  = pp_gen(mp, ml, sgn);
      assign stg_vld_s[s] = in_valid;
    end else begin : g_body
      assign stg_in_s[s]  = rows_r[s-1];
      assign stg_vld_s[s] = vld_r[s-1];
    end
    assign stg_out_s[s] = reduce_span(stg_in_s[s], (s * L) / STAGES,
                                      ((s + 1) * L) / STAGES);
  end

  // Final carry-propagate adder on the two remaining rows
  always_comb begin
    sum_s = cpa(stg_out_s[STAGES-1]);
  end

  // Pipeline and output registers shift together and hold on stall.
  // Bubbles shift like data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        rows_r[i] <= '0;
      end
      vld_r     <= '0;
      prod      <= '0;
      out_valid <= 1'b0;
    end else if (adv_s) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        rows_r[i] <= stg_out_s[i];
        vld_r[i]  <= stg_vld_s[i];
      end
      prod      <= sum_s;
      out_valid <= stg_vld_s[STAGES-1];
    end
  end

`ifdef WALLACE_MULT_ACC_EN
  logic [STAGES-1:0][1:0] stg_side_s;           // {acc_clr, sgn} per stage input
  logic [NR-1:0][1:0]     side_r;
  logic                   out_sgn_r;
  logic                   out_clr_r;
  logic [W+3:0]           prod_ext_s;

  for (genvar s = 0; s < STAGES; s++) begin : g_side
    if (s == 0) begin : g_head
      assign stg_side_s[s] = {acc_clr, sgn};
    end else begin : g_body
      assign stg_side_s[s] = side_r[s-1];
    end
  end

  // Mode and clear flags follow their transaction through the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      side_r    <= '0;
      out_sgn_r <= 1'b0;
      out_clr_r <= 1'b0;
    end else if (adv_s) begin
      for (int i = 0; i < STAGES - 1; i++) begin
        side_r[i] <= stg_side_s[i];
      end
      out_clr_r <= stg_side_s[STAGES-1][1];
      out_sgn_r <= stg_side_s[STAGES-1][0];
    end
  end

  // Extend the product according to its own transaction's mode
  always_comb begin
    prod_ext_s = {{4{out_sgn_r & prod[W-1]}}, prod};
  end

  // Accumulate on each output transfer (wraps modulo 2^(2N+4))
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (out_valid && out_ready) begin
      if (out_clr_r) begin
        acc <= prod_ext_s;
      end else begin
        acc <= acc + prod_ext_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_wallace_mult_pipe
//   Directed and random stimulus for wallace_mult_pipe (N=8, STAGES=3).
//   Expected products are queued in acceptance order. They are compared
//   when each output transfer takes place.
// ---------------------------------------------------------------------------
module tb_wallace_mult_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mp;
  logic [7:0]  ml;
  logic        sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
`ifdef WALLACE_MULT_ACC_EN
  logic        acc_clr;
  logic [19:0] acc;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  int          n_acc  = 0;
  int          n_out  = 0;
  logic        lat_chk = 1'b0;
  logic [15:0] exp_q[$];
  int          cyc_q[$];

  wallace_mult_pipe #(.N(8), .STAGES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mp        (mp),
    .ml        (ml),
    .sgn       (sgn),
`ifdef WALLACE_MULT_ACC_EN
    .acc_clr   (acc_clr),
    .acc       (acc),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
    logic [15:0] xa;
    logic [15:0] xb;
    xa = s ? {{8{a[7]}}, a} : {8'h00, a};
    xb = s ? {{8{b[7]}}, b} : {8'h00, b};
    return xa * xb;
  endfunction

  // One clock cycle: drive inputs after the falling edge, then score any
  // output transfer and record any input transfer for the coming edge.
  task automatic step(input logic sync, input logic iv, input logic [7:0] a,
                      input logic [7:0] b, input logic s, input logic ordy,
                      input logic [15:0] e, output logic took);
    logic [15:0] front;
    int          c0;
    if (sync) @(negedge clk);
    in_valid  = iv;
    mp        = a;
    ml        = b;
    sgn       = s;
    out_ready = ordy;
    #1;
    took = iv & in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        front = exp_q.pop_front();
        c0    = cyc_q.pop_front();
        chk("prod", 32'(prod), 32'(front));
        if (lat_chk) chk("latency", 32'(cyc_n - c0), 32'd3);
      end
    end
    if (took) begin
      n_acc++;
      exp_q.push_back(e);
      cyc_q.push_back(cyc_n);
    end
    cyc_n++;
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [15:0] e);
    logic t;
    step(1'b1, 1'b1, a, b, s, 1'b1, e, t);
    chk("accept", 32'(t), 32'd1);
  endtask

  task automatic drain();
    logic t;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() > 0) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, t);
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic [7:0]  bp_a [6] = '{8'h03, 8'hFF, 8'h12, 8'h80, 8'h7F, 8'hC8};
  logic [7:0]  bp_b [6] = '{8'h05, 8'hFF, 8'h34, 8'h01, 8'h80, 8'h64};
  logic        bp_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] bp_e [6] = '{16'h000F, 16'h0001, 16'h03A8, 16'hFF80, 16'h3F80, 16'hEA20};

  initial begin
    logic        t;
    logic        ordy;
    logic        stalled;
    logic [15:0] snap_p;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        rs;
    int          idx;
    int          stall;
    int          out0;
    int          acc0;

    rst = 1'b1; in_valid = 1'b0; mp = 8'h00; ml = 8'h00; sgn = 1'b0; out_ready = 1'b1;
`ifdef WALLACE_MULT_ACC_EN
    acc_clr = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_prod", 32'(prod), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Unsigned back-to-back, latency checked
    lat_chk = 1'b1;
    op(8'h00, 8'h00, 1'b0, 16'h0000);
    op(8'h01, 8'h02, 1'b0, 16'h0002);
    op(8'h0B, 8'h0B, 1'b0, 16'h0079);
    op(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    drain();

    // Signed with unsigned interleaved
    op(8'hFF, 8'h02, 1'b1, 16'hFFFE);
    op(8'hFF, 8'h02, 1'b0, 16'h01FE);
    op(8'h80, 8'h80, 1'b1, 16'h4000);
    op(8'h80, 8'h80, 1'b0, 16'h4000);
    op(8'h80, 8'h7F, 1'b1, 16'hC080);
    op(8'h7F, 8'h7F, 1'b1, 16'h3F01);
    drain();
    lat_chk = 1'b0;

    // Backpressure: out_ready low for 5 cycles once the first result shows
    idx = 0; stall = 0; snap_p = 16'h0000; out0 = n_out;
    for (int k = 0; k < 60; k++) begin
      if ((idx < 6) || (exp_q.size() > 0)) begin
        @(negedge clk);
        ordy    = 1'b1;
        stalled = 1'b0;
        if (out_valid && (stall < 5)) begin
          ordy    = 1'b0;
          stalled = 1'b1;
          if (stall == 0) begin
            snap_p = prod;
          end else begin
            chk("stall_prod", 32'(prod), 32'(snap_p));
            chk("stall_valid", 32'(out_valid), 32'd1);
          end
          stall++;
        end
        if (idx < 6) step(1'b0, 1'b1, bp_a[idx], bp_b[idx], bp_s[idx], ordy, bp_e[idx], t);
        else         step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, ordy, 16'h0000, t);
        if (stalled) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (t) idx++;
      end
    end
    chk("bp_accepted", 32'(idx), 32'd6);
    chk("bp_outputs", 32'(n_out - out0), 32'd6);
    chk("bp_stall_len", 32'(stall), 32'd5);
    drain();

    // Reset with three operations in flight
    op(8'h02, 8'h03, 1'b0, 16'h0006);
    op(8'h04, 8'h04, 1'b0, 16'h0010);
    op(8'h06, 8'h07, 1'b0, 16'h002A);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_prod", 32'(prod), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    lat_chk = 1'b1;
    op(8'h05, 8'h05, 1'b0, 16'h0019);
    drain();
    lat_chk = 1'b0;

    // Random sweep against the reference model
    out0 = n_out; acc0 = n_acc;
    for (int k = 0; k < 400; k++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      rs   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      step(1'b1, ($urandom_range(0, 3) != 0), ra, rb, rs, ordy, ref_mul(ra, rb, rs), t);
    end
    drain();
    chk("rand_count", 32'(n_out - out0), 32'(n_acc - acc0));

`ifdef WALLACE_MULT_ACC_EN
    acc_clr = 1'b1;
    op(8'h03, 8'h04, 1'b0, 16'h000C);
    acc_clr = 1'b0;
    op(8'hFF, 8'h01, 1'b1, 16'hFFFF);
    op(8'h0A, 8'h0A, 1'b0, 16'h0064);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, t);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, t);
    chk("acc_12", 32'(acc), 32'd12);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, t);
    chk("acc_11", 32'(acc), 32'd11);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 16'h0000, t);
    chk("acc_111", 32'(acc), 32'd111);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
